// File: rtl/wm_water_arbiter.sv
// Round-robin owner of the shared mains water-inlet valve for NUM_WM washing machines.
// Tick-based slices cap how long one owner holds the valve, and a closed-valve gap separates owners.
module wm_water_arbiter #(
    parameter int NUM_WM      = 4,
    parameter int SLICE_TICKS = 8,
    parameter int SWITCH_GAP  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic [NUM_WM-1:0]         req,
    output logic [NUM_WM-1:0]         grant,
    output logic                      valve_open,
    output logic [$clog2(NUM_WM)-1:0] owner_id,
    output logic                      preempt
);

    localparam int IDW = $clog2(NUM_WM);
    localparam int SW  = $clog2(SLICE_TICKS + 1);
    localparam int GW  = $clog2(SWITCH_GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [NUM_WM-1:0] r_grant;
    logic              r_valve_open;
    logic [IDW-1:0]    r_owner_id;
    logic              r_preempt;
    logic [IDW-1:0]    r_rr_ptr;
    logic [SW-1:0]     r_slice_cnt;
    logic [GW-1:0]     r_gap_cnt;

    logic              w_arb_found;
    logic [IDW-1:0]    w_arb_idx;
    logic [IDW-1:0]    w_next_ptr;
    logic              w_owner_req;
    logic              w_others_req;
    logic              w_slice_full;

    // Scan from rr_ptr upward with wrap; iterating backwards lets the nearest candidate win.
    always_comb begin
        int idx;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        idx         = 0;
        for (int k = NUM_WM - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_WM) begin
                idx = idx - NUM_WM;
            end
            if (req[idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = IDW'(idx);
            end
        end
    end

    assign w_next_ptr   = (r_owner_id == IDW'(NUM_WM - 1)) ? '0 : r_owner_id + 1'b1;
    assign w_owner_req  = req[r_owner_id];
    assign w_others_req = |(req & ~r_grant);
    assign w_slice_full = (r_slice_cnt == SW'(SLICE_TICKS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_valve_open <= 1'b0;
            r_owner_id   <= '0;
            r_preempt    <= 1'b0;
            r_rr_ptr     <= '0;
            r_slice_cnt  <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_found) begin
                        r_grant      <= NUM_WM'(1) << w_arb_idx;
                        r_valve_open <= 1'b1;
                        r_owner_id   <= w_arb_idx;
                        r_slice_cnt  <= '0;
                        r_state      <= ST_GRANT;
                    end
                end

                ST_GRANT: begin
                    if (tick && !w_slice_full) begin
                        r_slice_cnt <= r_slice_cnt + 1'b1;
                    end
                    // Release takes priority over expiry, so a voluntary drop never flags preempt.
                    if (!w_owner_req || (w_slice_full && w_others_req)) begin
                        r_grant      <= '0;
                        r_valve_open <= 1'b0;
                        r_rr_ptr     <= w_next_ptr;
                        r_gap_cnt    <= '0;
                        r_preempt    <= w_owner_req;
                        r_state      <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == GW'(SWITCH_GAP - 1)) begin
                        if (w_arb_found) begin
                            r_grant      <= NUM_WM'(1) << w_arb_idx;
                            r_valve_open <= 1'b1;
                            r_owner_id   <= w_arb_idx;
                            r_slice_cnt  <= '0;
                            r_state      <= ST_GRANT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_grant      <= '0;
                    r_valve_open <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign valve_open = r_valve_open;
    assign owner_id   = r_owner_id;
    assign preempt    = r_preempt;

endmodule

// File: tb/tb_wm_water_arbiter.sv
// Directed bench for wm_water_arbiter: single requester, rotation, slice expiry,
// coincident release/expiry, reset mid-grant and pointer wrap-around.
module tb_wm_water_arbiter;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] req  = 4'b0000;
    logic [3:0] grant;
    logic       valve_open;
    logic [1:0] owner_id;
    logic       preempt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wm_water_arbiter #(
        .NUM_WM      (4),
        .SLICE_TICKS (8),
        .SWITCH_GAP  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .req        (req),
        .grant      (grant),
        .valve_open (valve_open),
        .owner_id   (owner_id),
        .preempt    (preempt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; grant must never be multi-hot.
    task automatic cyc();
        @(posedge clk);
        #1;
        check("onehot0", {31'b0, $onehot0(grant)}, 32'd1);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] o, input logic p);
        check({tag, "_grant"},   {28'b0, grant},    {28'b0, g});
        check({tag, "_valve"},   {31'b0, valve_open}, {31'b0, |g});
        check({tag, "_owner"},   {30'b0, owner_id}, {30'b0, o});
        check({tag, "_preempt"}, {31'b0, preempt},  {31'b0, p});
    endtask

    initial begin
        logic [3:0] eg;
        logic [1:0] eo;

        // Reset state
        cyc();
        cyc();
        chk_out("reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;

        // 1. Single request, lone requester keeps the valve
        repeat (4) begin
            cyc();
            chk_out("t1_idle", 4'b0000, 2'd0, 1'b0);
        end
        req = 4'b0100;
        cyc();
        chk_out("t1_grant", 4'b0100, 2'd2, 1'b0);
        for (int t = 0; t < 20; t++) begin
            pulse_tick();
            cyc();
            chk_out("t1_hold", 4'b0100, 2'd2, 1'b0);
        end
        req = 4'b0000;
        cyc();
        chk_out("t1_gap1", 4'b0000, 2'd2, 1'b0);
        cyc();
        chk_out("t1_gap2", 4'b0000, 2'd2, 1'b0);
        cyc();
        chk_out("t1_idle_after", 4'b0000, 2'd2, 1'b0);

        // 2. Rotation with release after 3 ticks; 6. wrap-around on the last step
        rst = 1'b1;
        req = 4'b1111;
        cyc();
        rst = 1'b0;
        cyc();
        chk_out("t2_first", 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            repeat (3) begin
                pulse_tick();
                cyc();
            end
            req[i] = 1'b0;
            if (i == 3) req[0] = 1'b1;
            cyc();
            chk_out("t2_gap1", 4'b0000, 2'(i), 1'b0);
            cyc();
            chk_out("t2_gap2", 4'b0000, 2'(i), 1'b0);
            cyc();
            eg = 4'(1 << ((i + 1) % 4));
            eo = 2'((i + 1) % 4);
            chk_out("t2_next", eg, eo, 1'b0);
        end

        // 3. Slice expiry with a second requester
        rst = 1'b1;
        req = 4'b0001;
        cyc();
        rst = 1'b0;
        cyc();
        chk_out("t3_grant0", 4'b0001, 2'd0, 1'b0);
        pulse_tick();
        cyc();
        pulse_tick();
        cyc();
        req = 4'b0011;
        for (int k = 3; k <= 7; k++) begin
            pulse_tick();
            cyc();
            chk_out("t3_hold", 4'b0001, 2'd0, 1'b0);
        end
        pulse_tick();
        chk_out("t3_tick8", 4'b0001, 2'd0, 1'b0);
        cyc();
        chk_out("t3_preempt", 4'b0000, 2'd0, 1'b1);
        cyc();
        chk_out("t3_gap2", 4'b0000, 2'd0, 1'b0);
        cyc();
        chk_out("t3_grant1", 4'b0010, 2'd1, 1'b0);
        req = 4'b0001;
        cyc();
        cyc();
        cyc();
        chk_out("t3_back0", 4'b0001, 2'd0, 1'b0);

        // 4. Owner releases in the cycle the slice is full
        req = 4'b0011;
        repeat (7) begin
            pulse_tick();
            cyc();
        end
        pulse_tick();
        chk_out("t4_full", 4'b0001, 2'd0, 1'b0);
        req = 4'b0010;
        cyc();
        chk_out("t4_release", 4'b0000, 2'd0, 1'b0);
        cyc();
        chk_out("t4_gap2", 4'b0000, 2'd0, 1'b0);
        cyc();
        chk_out("t4_next", 4'b0010, 2'd1, 1'b0);

        // 5. Reset mid-grant
        req = 4'b0100;
        cyc();
        cyc();
        cyc();
        chk_out("t5_grant2", 4'b0100, 2'd2, 1'b0);
        rst = 1'b1;
        req = 4'b0110;
        cyc();
        chk_out("t5_reset", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        cyc();
        chk_out("t5_after", 4'b0010, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
